// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the SoC memory interconnect: access-type encodings,
// default widths, arbiter lock states and a width helper.
package soc_bus_pkg;

  localparam int unsigned DEF_NUM_MST    = 2;
  localparam int unsigned DEF_AW         = 32;
  localparam int unsigned DEF_DW         = 32;
  localparam int unsigned DEF_RWTYP_W    = 3;
  localparam int unsigned DEF_OUTS_DEPTH = 2;

  // Access types: bit 2 selects zero-extension on loads
  localparam logic [2:0] RWTYP_LB  = 3'b000;
  localparam logic [2:0] RWTYP_LH  = 3'b001;
  localparam logic [2:0] RWTYP_LW  = 3'b010;
  localparam logic [2:0] RWTYP_LBU = 3'b100;
  localparam logic [2:0] RWTYP_LHU = 3'b101;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width for n items, never below 1 bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_id_fifo.sv
// Synchronous FIFO holding the master index of each in-flight slave request.
module soc_id_fifo
  import soc_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// N-master to 1-slave round-robin memory arbiter with in-order response routing.
// Optional protocol checker enabled by SOC_ARB_ERR_CHK_EN.
module soc_mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned NUM_MST    = DEF_NUM_MST,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned RWTYP_W    = DEF_RWTYP_W,
  parameter int unsigned OUTS_DEPTH = DEF_OUTS_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MST-1:0]         m_req_vld,
  output logic [NUM_MST-1:0]         m_req_rdy,
  input  logic [NUM_MST-1:0]         m_req_wen,
  input  logic [NUM_MST*RWTYP_W-1:0] m_req_rwtyp,
  input  logic [NUM_MST*AW-1:0]      m_req_addr,
  input  logic [NUM_MST*DW-1:0]      m_req_wdata,
  output logic [NUM_MST-1:0]         m_rsp_vld,
  input  logic [NUM_MST-1:0]         m_rsp_rdy,
  output logic [DW-1:0]              m_rsp_rdata,
  output logic                       s_req_vld,
  input  logic                       s_req_rdy,
  output logic                       s_req_wen,
  output logic [RWTYP_W-1:0]         s_req_rwtyp,
  output logic [AW-1:0]              s_req_addr,
  output logic [DW-1:0]              s_req_wdata,
  input  logic                       s_rsp_vld,
  output logic                       s_rsp_rdy,
  input  logic [DW-1:0]              s_rsp_rdata,
  output logic                       arb_err
);

  localparam int unsigned IDX_W = clog2_min1(NUM_MST);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] arb_idx, gnt;
  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             req_vld, req_hs, rsp_hs, locked;

  // Round-robin search starting at rr_ptr
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    found   = 1'b0;
    idx     = '0;
    arb_idx = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_MST);
      if (!found && m_req_vld[idx]) begin
        found   = 1'b1;
        arb_idx = idx;
      end
    end
  end

  assign locked  = (state_q == ARB_LOCKED);
  assign gnt     = locked ? lock_idx_q : arb_idx;
  assign req_vld = !rst && (|m_req_vld) && !fifo_full;
  assign req_hs  = req_vld && s_req_rdy;
  assign rsp_hs  = s_rsp_vld && s_rsp_rdy;

  // Request mux; payload forced to zero while no request is presented
  always_comb begin
    s_req_vld   = req_vld;
    s_req_wen   = 1'b0;
    s_req_rwtyp = '0;
    s_req_addr  = '0;
    s_req_wdata = '0;
    m_req_rdy   = '0;
    if (req_vld) begin
      s_req_wen   = m_req_wen[gnt];
      s_req_rwtyp = m_req_rwtyp[gnt*RWTYP_W +: RWTYP_W];
      s_req_addr  = m_req_addr[gnt*AW +: AW];
      s_req_wdata = m_req_wdata[gnt*DW +: DW];
    end
    if (!rst && !fifo_full && s_req_rdy) begin
      m_req_rdy[gnt] = 1'b1;
    end
  end

  // Response routing to the master at the FIFO head
  always_comb begin
    m_rsp_vld   = '0;
    m_rsp_rdata = '0;
    s_rsp_rdy   = 1'b0;
    if (!fifo_empty) begin
      m_rsp_vld[fifo_head] = s_rsp_vld;
      m_rsp_rdata          = s_rsp_rdata;
      s_rsp_rdy            = m_rsp_rdy[fifo_head];
    end
  end

  // Grant holds while the slave stalls a presented request
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (req_hs) begin
      state_d  = ARB_OPEN;
      rr_ptr_d = (gnt == IDX_W'(NUM_MST - 1)) ? '0 : gnt + IDX_W'(1);
    end else if (req_vld) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_OPEN;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  soc_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTS_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs),
    .din   (gnt),
    .pop   (rsp_hs),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

`ifdef SOC_ARB_ERR_CHK_EN
  logic arb_err_q, arb_err_d;

  // Sticky: stray slave response, or locked master dropping its request
  always_comb begin
    arb_err_d = arb_err_q;
    if ((s_rsp_vld && fifo_empty) || (locked && !m_req_vld[lock_idx_q])) begin
      arb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_err_q <= 1'b0;
    end else begin
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule
